// File: rtl/record_pkg.sv
// record_pkg -- types shared by the record FIFO and its users.
//   record_t : packed record {a, aa, aaa}; field width set by WIDTH below,
//              which matches the record_fifo default so a record_t packs to
//              exactly the FIFO's i_rec/o_rec width (2*WIDTH+32).
//   kind_t   : 2-bit record kind; value 0 is never stored.
//   occ_t    : FIFO occupancy state.
package record_pkg;

    localparam int WIDTH = 10;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] aa;
        int unsigned      aaa;
    } record_t;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_X    = 2'd1,
        KIND_Y    = 2'd2,
        KIND_Z    = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage

// File: rtl/record_fifo.sv
// record_fifo -- first-word fall-through FIFO of {record, kind} entries with a
// per-kind accept filter. Records whose kind is 0 or masked off are accepted
// (handshake completes) but discarded and counted in a saturating drop counter.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     synchronous active-low reset
//   i_kind_en   accept mask, bit0=KIND_X, bit1=KIND_Y, bit2=KIND_Z
//   i_valid     upstream record valid       o_ready  can accept a record
//   i_rec       record {a, aa, aaa}         i_kind   record kind
//   o_valid     head record valid           i_ready  downstream takes head
//   o_rec       head record                 o_kind   head record kind
//   o_count     stored entries              o_state  occupancy (occ_t)
//   o_drop_cnt  discarded-record count, saturates at 255
module record_fifo
    import record_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 4,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [2:0]            i_kind_en,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2*WIDTH+31:0]   i_rec,
    input  logic [1:0]            i_kind,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*WIDTH+31:0]   o_rec,
    output logic [1:0]            o_kind,
    output logic [CNTW-1:0]       o_count,
    output logic [1:0]            o_state,
    output logic [7:0]            o_drop_cnt
);

    localparam int REC_W = 2 * WIDTH + 32;
    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [REC_W-1:0] mem_rec  [DEPTH];
    logic [1:0]       mem_kind [DEPTH];

    logic [PTRW-1:0]  wr_ptr, rd_ptr;
    logic [CNTW-1:0]  count, count_nxt;
    logic [7:0]       drop_cnt;
    occ_t             state, state_nxt;

    logic push, pop, kind_ok, store, drop;

    assign o_valid = (state != OCC_EMPTY);
    assign o_ready = (state != OCC_FULL);

    assign push  = i_valid && o_ready;
    assign pop   = o_valid && i_ready;

    // Kind 0 has no mask bit and is always rejected.
    always_comb begin
        kind_ok = 1'b0;
        case (i_kind)
            KIND_X:  kind_ok = i_kind_en[0];
            KIND_Y:  kind_ok = i_kind_en[1];
            KIND_Z:  kind_ok = i_kind_en[2];
            default: kind_ok = 1'b0;
        endcase
    end

    assign store = push && kind_ok;
    assign drop  = push && !kind_ok;

    assign count_nxt = count + CNTW'(store) - CNTW'(pop);

    // Occupancy is a function of the post-edge count so state and count
    // never disagree.
    always_comb begin
        state_nxt = OCC_PARTIAL;
        if (count_nxt == '0)
            state_nxt = OCC_EMPTY;
        else if (count_nxt == CNTW'(DEPTH))
            state_nxt = OCC_FULL;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= OCC_EMPTY;
        else
            state <= state_nxt;
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            count <= count_nxt;
            if (store)
                wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTRW'(1);
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage is not cleared by reset; the reset guard only keeps a push
    // presented during reset from landing in the array.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && store) begin
            mem_rec[wr_ptr]  <= i_rec;
            mem_kind[wr_ptr] <= i_kind;
        end
    end

    assign o_rec      = mem_rec[rd_ptr];
    assign o_kind     = mem_kind[rd_ptr];
    assign o_count    = count;
    assign o_state    = state;
    assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_record_fifo.sv
module tb_record_fifo;
    import record_pkg::*;

    localparam int W     = 10;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int RW    = 2 * W + 32;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [2:0]      i_kind_en;
    logic            i_valid;
    logic            o_ready;
    logic [RW-1:0]   i_rec;
    logic [1:0]      i_kind;
    logic            o_valid;
    logic            i_ready;
    logic [RW-1:0]   o_rec;
    logic [1:0]      o_kind;
    logic [CNTW-1:0] o_count;
    logic [1:0]      o_state;
    logic [7:0]      o_drop_cnt;

    record_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_kind_en(i_kind_en),
        .i_valid(i_valid), .o_ready(o_ready), .i_rec(i_rec), .i_kind(i_kind),
        .o_valid(o_valid), .i_ready(i_ready), .o_rec(o_rec), .o_kind(o_kind),
        .o_count(o_count), .o_state(o_state), .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [RW-1:0] rec;
        logic [1:0]    kind;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit kind_en(input logic [1:0] k);
        case (k)
            2'd1:    return i_kind_en[0];
            2'd2:    return i_kind_en[1];
            2'd3:    return i_kind_en[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic record_t mk(input int a, input int aa, input int aaa);
        record_t r;
        r.a   = W'(a);
        r.aa  = W'(aa);
        r.aaa = aaa;
        return r;
    endfunction

    // Starts and ends at posedge+1. Holds the record until the DUT is ready,
    // then updates the scoreboard/drop model for the completed handshake.
    task automatic push(input record_t r, input logic [1:0] k);
        bit   done = 0;
        exp_t e;
        i_valid = 1'b1;
        i_rec   = r;
        i_kind  = k;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge i_clk);
            if (o_ready) done = 1;
            @(posedge i_clk); #1;
        end
        if (!done) chk("push_timeout", 64'd0, 64'd1);
        else if (kind_en(k)) begin
            e.rec = r; e.kind = k;
            q.push_back(e);
        end else if (exp_drop < 255) exp_drop++;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit empty = 0;
        i_ready = 1'b1;
        for (int c = 0; c < 20 && !empty; c++) begin
            @(negedge i_clk);
            if (!o_valid) empty = 1;
        end
        chk({name, "_empty"}, 64'(o_valid), 64'd0);
        chk({name, "_state"}, 64'(o_state), 64'(OCC_EMPTY));
        chk({name, "_sb"}, 64'(q.size()), 64'd0);
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    initial begin
        bit seen_valid;
        i_rst_n = 1'b0; i_kind_en = 3'b111; i_valid = 1'b0; i_ready = 1'b0;
        i_rec = '0; i_kind = 2'd0;

        // Scoreboard monitor: a pop happens on the edge after a negedge that
        // sees o_valid && i_ready outside reset.
        fork
            forever begin
                @(negedge i_clk);
                if (i_rst_n && o_valid && i_ready) begin
                    if (q.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
                    else begin
                        chk("pop_rec", 64'(o_rec), 64'(q[0].rec));
                        chk("pop_kind", 64'(o_kind), 64'(q[0].kind));
                        void'(q.pop_front());
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_state", 64'(o_state), 64'(OCC_EMPTY));
        chk("rst_drop", 64'(o_drop_cnt), 64'd0);
        @(posedge i_clk); #1;

        // Single record, fall-through on the next cycle
        push(mk(1, 1, 1), KIND_X);
        @(negedge i_clk);
        chk("one_valid", 64'(o_valid), 64'd1);
        chk("one_count", 64'(o_count), 64'd1);
        chk("one_state", 64'(o_state), 64'(OCC_PARTIAL));
        @(posedge i_clk); #1;
        drain("one");

        // Fill to FULL, fifth record held off
        for (int i = 0; i < 4; i++) push(mk(16 + i, 32 + i, 100 + i), KIND_Y);
        @(negedge i_clk);
        chk("full_ready", 64'(o_ready), 64'd0);
        chk("full_state", 64'(o_state), 64'(OCC_FULL));
        chk("full_count", 64'(o_count), 64'd4);
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_rec = mk(99, 99, 99); i_kind = KIND_Y;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("full_hold_count", 64'(o_count), 64'd4);
        chk("full_hold_ready", 64'(o_ready), 64'd0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        drain("full");

        // Mask 101: KIND_Y dropped, KIND_Z stored
        i_kind_en = 3'b101;
        push(mk(5, 6, 7), KIND_Y);
        push(mk(8, 9, 10), KIND_Z);
        @(negedge i_clk);
        chk("mask_drop", 64'(o_drop_cnt), 64'd1);
        chk("mask_count", 64'(o_count), 64'd1);
        chk("mask_kind", 64'(o_kind), 64'(KIND_Z));
        @(posedge i_clk); #1;
        drain("mask");

        // Steady push+pop at count 2, pointers wrap
        i_kind_en = 3'b111;
        push(mk(200, 201, 202), KIND_X);
        push(mk(203, 204, 205), KIND_Z);
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(mk(300 + i, 400 + i, 500 + i), 2'(1 + i % 3));
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("stream_count", 64'(o_count), 64'd2);
        chk("stream_state", 64'(o_state), 64'(OCC_PARTIAL));
        @(posedge i_clk); #1;
        drain("stream");

        // Dropped push concurrent with a pop
        push(mk(7, 7, 7), KIND_X);
        i_ready = 1'b1;
        push(mk(0, 0, 0), KIND_NONE);
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("droppop_count", 64'(o_count), 64'd0);
        chk("droppop_drop", 64'(o_drop_cnt), 64'(exp_drop));
        @(posedge i_clk); #1;

        // Drop counter saturation
        seen_valid = 0;
        for (int i = 0; i < 300; i++) begin
            push(mk(i, i, i), KIND_NONE);
            seen_valid |= o_valid;
        end
        chk("sat_drop", 64'(o_drop_cnt), 64'd255);
        chk("sat_model", 64'(exp_drop), 64'd255);
        chk("sat_novalid", 64'(seen_valid), 64'd0);

        // Reset mid-operation with a push presented in the reset cycle
        for (int i = 0; i < 3; i++) push(mk(50 + i, 60 + i, 70 + i), KIND_X);
        @(negedge i_clk);
        chk("pre_rst_count", 64'(o_count), 64'd3);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0; i_valid = 1'b1; i_rec = mk(1, 2, 3); i_kind = KIND_X;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_valid = 1'b0;
        q.delete();
        exp_drop = 0;
        @(negedge i_clk);
        chk("mrst_count", 64'(o_count), 64'd0);
        chk("mrst_state", 64'(o_state), 64'(OCC_EMPTY));
        chk("mrst_ready", 64'(o_ready), 64'd1);
        chk("mrst_drop", 64'(o_drop_cnt), 64'd0);
        chk("mrst_valid", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        chk("mrst_valid2", 64'(o_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
